// File: rtl/divider32.sv
// Multi-cycle radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU.
// Shares the start/done/move_flush handshake with the multiplier.
module divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             move_flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic [CW-1:0]    counter;
  logic             neg_q, neg_r;

  logic             a_neg, b_neg, div_zero, overflow;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift, diff;

  assign a_neg    = is_signed & a[WIDTH-1];
  assign b_neg    = is_signed & b[WIDTH-1];
  assign abs_a    = a_neg ? -a : a;
  assign abs_b    = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign overflow = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // quot doubles as the dividend shift register: its MSB feeds the partial
  // remainder while new quotient bits enter at the LSB.
  assign rem_shift = {rem, quot[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor};

  assign done = (state == FINISH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (div_zero || overflow) ? FINISH : CALC;
      CALC:    if (counter == CW'(1)) state_next = FIX;
      FIX:     state_next = FINISH;
      FINISH:  if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (move_flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      r       <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      counter <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (move_flush) begin
      q       <= '0;
      r       <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      counter <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              q <= '1;
              r <= a;
            end else if (overflow) begin
              q <= a;
              r <= '0;
            end else begin
              rem     <= '0;
              quot    <= abs_a;
              divisor <= abs_b;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              counter <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem  <= diff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= rem_shift[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          counter <= counter - CW'(1);
        end
        FIX: begin
          q <= neg_q ? -quot : quot;
          r <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule
